// File: rtl/philo_agent.sv
// philo_agent: dining-philosopher agent cycling THINKING -> HUNGRY -> EATING on a prescaled tick.
module philo_agent #(
  parameter int ID         = 0,
  parameter int THINK_TIME = 5,
  parameter int EAT_TIME   = 2,
  parameter int TICK_DIV   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] event_p,
  output logic [3:0] event_s,
  output logic [1:0] state,
  output logic [7:0] meals,
  output logic       protocol_err
);
  typedef enum logic [1:0] {THINKING = 2'd0, HUNGRY = 2'd1, EATING = 2'd2} st_t;
  localparam logic [15:0] PMAX = 16'(TICK_DIV - 1);
  localparam logic [7:0]  TT   = 8'(THINK_TIME);
  localparam logic [7:0]  ET   = 8'(EAT_TIME);
  localparam logic [1:0]  IDV  = 2'(ID);
  st_t         state_q, state_d;
  logic [15:0] pre_q, pre_d;
  logic [7:0]  cnt_q, cnt_d, meals_q, meals_d;
  logic [3:0]  ev_q, ev_d;
  logic        err_q, err_d;
  logic        tick, eat;
  assign tick = pre_q == PMAX;
  assign eat  = event_p[2] && event_p[1:0] == 2'd0;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= THINKING;
      pre_q   <= '0;
      cnt_q   <= TT;
      ev_q    <= '0;
      meals_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      ev_q    <= ev_d;
      meals_q <= meals_d;
      err_q   <= err_d;
    end
  end
  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    cnt_d   = cnt_q;
    ev_d    = {1'b0, ev_q[2:0]};
    meals_d = meals_q;
    err_d   = err_q;
    if (state_q == HUNGRY) begin
      if (eat) begin
        state_d = EATING;
        pre_d   = '0;
        cnt_d   = ET;
      end
    end else begin
      // EAT is only legal while HUNGRY; elsewhere it only raises the sticky error
      err_d = err_q | eat;
      pre_d = tick ? '0 : pre_q + 16'd1;
      if (tick) cnt_d = cnt_q - 8'd1;
      if (tick && cnt_q == 8'd1) begin
        if (state_q == THINKING) begin
          state_d = HUNGRY;
          ev_d    = {2'b10, IDV};
        end else begin
          state_d = THINKING;
          cnt_d   = TT;
          ev_d    = {2'b11, IDV};
          meals_d = meals_q + 8'd1;
        end
      end
    end
  end
  assign event_s      = ev_q;
  assign state        = state_q;
  assign meals        = meals_q;
  assign protocol_err = err_q;
endmodule

// File: tb/tb_philo_agent.sv
// tb_philo_agent: directed checks of philo_agent with default and custom parameters.
module tb_philo_agent;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] ep_a = '0, ep_b = '0;
  logic [3:0] es_a, es_b;
  logic [1:0] st_a, st_b;
  logic [7:0] m_a, m_b;
  logic       er_a, er_b;
  int checks = 0, failures = 0;

  philo_agent dut_a (
    .clk(clk), .reset(rst_n), .event_p(ep_a), .event_s(es_a),
    .state(st_a), .meals(m_a), .protocol_err(er_a)
  );
  philo_agent #(.ID(2), .THINK_TIME(2), .EAT_TIME(2), .TICK_DIV(3)) dut_b (
    .clk(clk), .reset(rst_n), .event_p(ep_b), .event_s(es_b),
    .state(st_b), .meals(m_b), .protocol_err(er_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] exp_m;
    #12;
    chk("rst_state_a", 8'(st_a), 8'd0);
    chk("rst_ev_a", 8'(es_a), 8'd0);
    chk("rst_meals_a", m_a, 8'd0);
    chk("rst_err_a", 8'(er_a), 8'd0);
    chk("rst_state_b", 8'(st_b), 8'd0);
    #10 rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("think_ev_a", 8'(es_a), 8'h0);
      chk("think_st_a", 8'(st_a), 8'd0);
    end
    chk("think_st_b_e4", 8'(st_b), 8'd0);
    step();
    chk("hungry_ev_a_e5", 8'(es_a), 8'h8);
    chk("hungry_st_a_e5", 8'(st_a), 8'd1);
    chk("ev_b_e5", 8'(es_b), 8'h0);
    step();
    chk("ev_a_e6", 8'(es_a), 8'h0);
    chk("st_a_e6", 8'(st_a), 8'd1);
    chk("hungry_ev_b_e6", 8'(es_b), 8'hA);
    chk("hungry_st_b_e6", 8'(st_b), 8'd1);
    step();
    chk("ev_b_e7", 8'(es_b), 8'h2);
    ep_a = 3'b111;
    step();
    chk("reserved_st_a", 8'(st_a), 8'd1);
    chk("reserved_err_a", 8'(er_a), 8'd0);
    ep_a = 3'b100;
    step();
    ep_a = 3'b000;
    chk("eat_st_a_e9", 8'(st_a), 8'd2);
    step();
    chk("eat_st_a_e10", 8'(st_a), 8'd2);
    chk("eat_ev_a_e10", 8'(es_a), 8'h0);
    step();
    chk("done_ev_a_e11", 8'(es_a), 8'hC);
    chk("done_st_a_e11", 8'(st_a), 8'd0);
    chk("done_meals_a", m_a, 8'd1);
    step();
    chk("ev_a_e12", 8'(es_a), 8'h4);
    ep_a = 3'b100;
    step();
    ep_a = 3'b000;
    chk("err_think_a_e13", 8'(er_a), 8'd1);
    chk("err_think_st_a", 8'(st_a), 8'd0);
    step();
    step();
    chk("st_a_e15", 8'(st_a), 8'd0);
    step();
    chk("hungry2_st_a_e16", 8'(st_a), 8'd1);
    chk("hungry2_ev_a_e16", 8'(es_a), 8'h8);
    chk("err_sticky_a", 8'(er_a), 8'd1);
    ep_b = 3'b100;
    step();
    ep_b = 3'b000;
    chk("eat_st_b_e17", 8'(st_b), 8'd2);
    for (int i = 18; i <= 22; i++) step();
    chk("eat_st_b_e22", 8'(st_b), 8'd2);
    chk("err_b_e22", 8'(er_b), 8'd0);
    ep_b = 3'b100;
    step();
    ep_b = 3'b000;
    chk("done_ev_b_e23", 8'(es_b), 8'hE);
    chk("done_st_b_e23", 8'(st_b), 8'd0);
    chk("done_meals_b", m_b, 8'd1);
    chk("done_err_b", 8'(er_b), 8'd1);
    exp_m = 8'd1;
    for (int n = 0; n < 255; n++) begin
      for (int t = 0; t < 20 && st_a !== 2'd1; t++) step();
      chk("loop_hungry", 8'(st_a), 8'd1);
      ep_a = 3'b100;
      step();
      ep_a = 3'b000;
      for (int t = 0; t < 20 && es_a[3] !== 1'b1; t++) step();
      exp_m = exp_m + 8'd1;
      chk("loop_done_ev", 8'(es_a), 8'hC);
      chk("loop_meals", m_a, exp_m);
    end
    chk("meals_wrap", m_a, 8'd0);
    for (int t = 0; t < 20 && st_a !== 2'd1; t++) step();
    ep_a = 3'b100;
    step();
    ep_a = 3'b000;
    chk("pre_rst_eating", 8'(st_a), 8'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_state", 8'(st_a), 8'd0);
    chk("async_rst_ev", 8'(es_a), 8'd0);
    chk("async_rst_meals", m_a, 8'd0);
    chk("async_rst_err", 8'(er_a), 8'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      chk("post_rst_no_done", 8'(es_a[2]), 8'd0);
      chk("post_rst_state", 8'(st_a), i >= 5 ? 8'd1 : 8'd0);
    end
    chk("post_rst_meals", m_a, 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/philo_agent.md
PHILO_AGENT -- requirements
Module: philo_agent

Interface
REQ-001 The block SHALL have parameter ID, default 0: philosopher index placed in every outgoing event, range 0..3.
REQ-002 The block SHALL have parameter THINK_TIME, default 5: thinking duration in ticks, range 1..255.
REQ-003 The block SHALL have parameter EAT_TIME, default 2: eating duration in ticks, range 1..255.
REQ-004 The block SHALL have parameter TICK_DIV, default 1: clocks per tick, range 1..65535.
REQ-005 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 The block SHALL have port event_p  input  3  table-to-philosopher event; bit2 = strobe, [1:0] = signal (0 = EAT; 1..3 reserved).
REQ-008 The block SHALL have port event_s  output  4  philosopher-to-table event; bit3 = strobe, bit2 = signal (0 = HUNGRY, 1 = DONE), [1:0] = ID.
REQ-009 The block SHALL have port state  output  2  current state: 0 THINKING, 1 HUNGRY, 2 EATING.
REQ-010 The block SHALL have port meals  output  8  count of completed eating periods.
REQ-011 The block SHALL have port protocol_err  output  1  sticky flag for an illegal inbound event.

Function
REQ-012 The block SHALL implement exactly three states, THINKING, HUNGRY and EATING, and SHALL never encode value 3 on state.
REQ-013 On every entry to THINKING or EATING, the block SHALL clear the prescaler and load the tick counter with THINK_TIME or EAT_TIME respectively.
REQ-014 The prescaler SHALL count 0..TICK_DIV-1 and wrap; a tick SHALL occur in the cycle where the prescaler equals TICK_DIV-1.
REQ-015 Each tick in THINKING or EATING SHALL decrement the tick counter; the prescaler and tick counter SHALL hold in HUNGRY.
REQ-016 A tick with counter equal to 1 in THINKING SHALL, at that same edge, move to HUNGRY and register event_s = {1, 0, ID}.
REQ-017 As a result of REQ-013 through REQ-016, state SHALL change THINKING->HUNGRY exactly THINK_TIME*TICK_DIV clocks after THINKING entry.
REQ-018 In HUNGRY, an event_p strobe with signal 0 SHALL move the block to EATING at the next edge.
REQ-019 A tick with counter equal to 1 in EATING SHALL, at that same edge, move to THINKING, register event_s = {1, 1, ID}, and increment meals.
REQ-020 meals SHALL wrap from 255 to 0.
REQ-021 The event_s strobe SHALL be high for exactly one clock.
REQ-022 event_s[2:0] SHALL hold its last value while the strobe is low.
REQ-023 Inbound events SHALL be sampled only when bit2 of event_p is high; the block SHALL treat a strobe held high for N clocks as N events.
REQ-024 In HUNGRY, an event_p strobe with a reserved signal (1..3) SHALL be ignored, SHALL leave the state unchanged, and SHALL NOT set protocol_err.
REQ-025 An EAT strobe in THINKING or EATING SHALL be ignored for state purposes and SHALL set protocol_err, which stays 1 until reset.
REQ-026 An EAT strobe in the same cycle that the HUNGRY event is registered (state still THINKING) SHALL be treated per REQ-025.
REQ-027 An EAT strobe in the same cycle that the DONE event is registered (state still EATING) SHALL be treated per REQ-025, and the DONE transition SHALL still occur.
REQ-028 No outbound event other than HUNGRY or DONE SHALL ever be generated, and the two SHALL alternate strictly starting with HUNGRY.

Reset
REQ-029 While reset = 0, the block SHALL hold: state = THINKING, event_s = 4'b0000, meals = 0, protocol_err = 0, prescaler = 0, tick counter = THINK_TIME, independent of clk.
REQ-030 Assertion of reset mid-operation (any state, including a cycle with the event_s strobe high) SHALL immediately force the REQ-029 values; no pending event SHALL be emitted after reset is released.
REQ-031 The first rising edge after reset deassertion SHALL count as cycle 1 of THINKING.

Verification
REQ-032 The bench SHALL verify: defaults, TICK_DIV=1, event_p idle, release reset -> event_s = 4'b1000 after edge 5 only, state = 1 from edge 5, strobe low after edge 6.
REQ-033 The bench SHALL verify: ID=2, TICK_DIV=3, THINK_TIME=2 -> HUNGRY strobe after edge 6 with event_s = 4'b1010.
REQ-034 The bench SHALL verify: in HUNGRY, one-clock EAT strobe at edge k -> state = 2 after edge k; DONE strobe event_s = {1,1,ID} after edge k+2 (EAT_TIME=2, TICK_DIV=1); meals = 1; state = 0.
REQ-035 The bench SHALL verify: EAT strobe while THINKING -> protocol_err = 1 persisting, state timing unchanged; reserved signal 3 while HUNGRY -> no change, no error.
REQ-036 The bench SHALL verify: run 256 think/eat cycles -> meals reads 0 after the 256th DONE.
REQ-037 The bench SHALL verify: assert reset during EATING -> outputs match REQ-029 within the same cycle, with no DONE strobe afterward until a full THINK/HUNGRY/EAT sequence completes.
